// File: rtl/swa_pkg.sv
// Shared definitions for the serial word adder.
// Contents: FSM state encoding and the byte width processed per cycle.
package swa_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } swa_state_e;

endpackage : swa_pkg

// File: rtl/conditional_sum_adder.sv
// 8-bit conditional sum adder: every block is summed for both possible
// carry-ins and the real carry selects between them, doubling the block
// size at each of three levels (1 -> 2 -> 4 -> 8 bits).
// Ports:
//   x, y : operand bytes
//   c0   : carry-in
//   S    : 8-bit sum
//   c8   : carry-out
module conditional_sum_adder
  import swa_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              c0,
  output logic [BYTE_W-1:0] S,
  output logic              c8
);

  // Level 0: single-bit blocks, sums/carries for carry-in 0 and 1.
  logic [7:0] sum_ci0_l0, sum_ci1_l0, cy_ci0_l0, cy_ci1_l0;
  // Level 1: 2-bit blocks.
  logic [7:0] sum_ci0_l1, sum_ci1_l1;
  logic [3:0] cy_ci0_l1, cy_ci1_l1;
  // Level 2: 4-bit blocks.
  logic [7:0] sum_ci0_l2, sum_ci1_l2;
  logic [1:0] cy_ci0_l2, cy_ci1_l2;
  // Level 3: whole byte.
  logic [7:0] sum_ci0_l3, sum_ci1_l3;
  logic       cy_ci0_l3, cy_ci1_l3;

  assign sum_ci0_l0 = x ^ y;
  assign sum_ci1_l0 = ~(x ^ y);
  assign cy_ci0_l0  = x & y;
  assign cy_ci1_l0  = x | y;

  // Merge pairs of 1-bit blocks; the lower block's carry picks the upper result.
  for (genvar k = 0; k < 4; k++) begin : g_lvl1
    assign sum_ci0_l1[2*k]   = sum_ci0_l0[2*k];
    assign sum_ci1_l1[2*k]   = sum_ci1_l0[2*k];
    assign sum_ci0_l1[2*k+1] = cy_ci0_l0[2*k] ? sum_ci1_l0[2*k+1] : sum_ci0_l0[2*k+1];
    assign sum_ci1_l1[2*k+1] = cy_ci1_l0[2*k] ? sum_ci1_l0[2*k+1] : sum_ci0_l0[2*k+1];
    assign cy_ci0_l1[k]      = cy_ci0_l0[2*k] ? cy_ci1_l0[2*k+1] : cy_ci0_l0[2*k+1];
    assign cy_ci1_l1[k]      = cy_ci1_l0[2*k] ? cy_ci1_l0[2*k+1] : cy_ci0_l0[2*k+1];
  end

  // Merge pairs of 2-bit blocks.
  for (genvar k = 0; k < 2; k++) begin : g_lvl2
    assign sum_ci0_l2[4*k +: 2]   = sum_ci0_l1[4*k +: 2];
    assign sum_ci1_l2[4*k +: 2]   = sum_ci1_l1[4*k +: 2];
    assign sum_ci0_l2[4*k+2 +: 2] = cy_ci0_l1[2*k] ? sum_ci1_l1[4*k+2 +: 2] : sum_ci0_l1[4*k+2 +: 2];
    assign sum_ci1_l2[4*k+2 +: 2] = cy_ci1_l1[2*k] ? sum_ci1_l1[4*k+2 +: 2] : sum_ci0_l1[4*k+2 +: 2];
    assign cy_ci0_l2[k]           = cy_ci0_l1[2*k] ? cy_ci1_l1[2*k+1] : cy_ci0_l1[2*k+1];
    assign cy_ci1_l2[k]           = cy_ci1_l1[2*k] ? cy_ci1_l1[2*k+1] : cy_ci0_l1[2*k+1];
  end

  // Merge the two nibbles.
  assign sum_ci0_l3[3:0] = sum_ci0_l2[3:0];
  assign sum_ci1_l3[3:0] = sum_ci1_l2[3:0];
  assign sum_ci0_l3[7:4] = cy_ci0_l2[0] ? sum_ci1_l2[7:4] : sum_ci0_l2[7:4];
  assign sum_ci1_l3[7:4] = cy_ci1_l2[0] ? sum_ci1_l2[7:4] : sum_ci0_l2[7:4];
  assign cy_ci0_l3       = cy_ci0_l2[0] ? cy_ci1_l2[1] : cy_ci0_l2[1];
  assign cy_ci1_l3       = cy_ci1_l2[0] ? cy_ci1_l2[1] : cy_ci0_l2[1];

  // Real carry-in makes the final selection.
  assign S  = c0 ? sum_ci1_l3 : sum_ci0_l3;
  assign c8 = c0 ? cy_ci1_l3  : cy_ci0_l3;

endmodule : conditional_sum_adder

// File: rtl/serial_word_adder.sv
// Byte-serial word adder: captures a, b and cin, then adds one byte per
// cycle through a single 8-bit conditional sum adder, LSB byte first.
// Result is presented with a valid/ready handshake.
// Optional feature: define SWA_SIGNED_OVERFLOW_EN to add the ovf output
// (signed two's-complement overflow of the whole word).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin            : operands and carry-in, sampled on accept
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, cout            : registered result and final carry
//   ovf                  : signed overflow (only with SWA_SIGNED_OVERFLOW_EN)
// NUM_BYTES legal range is 2..8.
module serial_word_adder
  import swa_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0] a,
  input  logic [BYTE_W*NUM_BYTES-1:0] b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] sum,
  output logic                        cout
`ifdef SWA_SIGNED_OVERFLOW_EN
  ,
  output logic                        ovf
`endif
);

  localparam int unsigned WORD_W   = BYTE_W * NUM_BYTES;
  localparam int unsigned IDX_W    = $clog2(NUM_BYTES);
  localparam int unsigned LAST_IDX = NUM_BYTES - 1;

  swa_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
`ifdef SWA_SIGNED_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  logic [BYTE_W-1:0] a_byte, b_byte, add_s;
  logic              add_c;

  // Current byte lane of the captured operands.
  assign a_byte = a_q[idx_q*BYTE_W +: BYTE_W];
  assign b_byte = b_q[idx_q*BYTE_W +: BYTE_W];

  conditional_sum_adder u_csa (
    .x  (a_byte),
    .y  (b_byte),
    .c0 (carry_q),
    .S  (add_s),
    .c8 (add_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SWA_SIGNED_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*BYTE_W +: BYTE_W] = add_s;
        carry_d = add_c;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(LAST_IDX)) begin
          cout_d  = add_c;
`ifdef SWA_SIGNED_OVERFLOW_EN
          // add_s[MSB] is the word sign bit on the last byte.
          ovf_d   = (a_q[WORD_W-1] == b_q[WORD_W-1]) &&
                    (add_s[BYTE_W-1] != a_q[WORD_W-1]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        // No re-accept on this edge: IDLE is entered first.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SWA_SIGNED_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SWA_SIGNED_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SWA_SIGNED_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule : serial_word_adder

// File: tb/tb_serial_word_adder.sv
// Directed bench for serial_word_adder (NUM_BYTES = 4).
module tb_serial_word_adder;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SWA_SIGNED_OVERFLOW_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_word_adder #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SWA_SIGNED_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation; hold > 0 keeps out_ready low that many cycles
  // while offering junk operands that must be ignored.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int hold);
    check("pre_in_ready", 64'(in_ready), 64'd1);
    a = op_a; b = op_b; cin = op_cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1; cin = 1'b1;
    check("accept_in_ready", 64'(in_ready), 64'd0);
    for (int c = 1; c <= int'(NB); c++) begin
      @(posedge clk); #1;
      if (c == int'(NB) - 1) check("early_out_valid", 64'(out_valid), 64'd0);
    end
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("sum", 64'(sum), 64'(exp_sum));
    check("cout", 64'(cout), 64'(exp_cout));
`ifdef SWA_SIGNED_OVERFLOW_EN
    check("ovf", 64'(ovf), 64'(exp_ovf));
`endif
    if (hold > 0) begin
      in_valid = 1'b1; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("hold_out_valid", 64'(out_valid), 64'd1);
        check("hold_sum", 64'(sum), 64'(exp_sum));
        check("hold_cout", 64'(cout), 64'(exp_cout));
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("idle_sum_kept", 64'(sum), 64'(exp_sum));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    #5 rst = 1'b0;

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 0);
    run_op(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 0);
    run_op(32'hDEADBEEF, 32'h21524110, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1, 1'b1, 0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 10);

    // Reset during the second RUN cycle.
    check("mid_pre_in_ready", 64'(in_ready), 64'd1);
    a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;

    run_op(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
    run_op(32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_word_adder
